// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// Uses radix-4 Booth multiply (16 iterations) and non-restoring divide on magnitudes (32 iterations).
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  counter;
  logic        fin;            // last iteration done; next edge completes
  logic [31:0] mcand;          // Booth multiplicand, or divisor magnitude
  // Booth register {upper[33:0], multiplier[31:0], extra}; the upper half keeps
  // two guard bits so adding +/-2M never overflows before the arithmetic shift.
  logic [66:0] prod;
  logic [33:0] rem;
  logic [31:0] quo;
  logic        neg_q, div_zero, div_ovf;

  logic        start;
  logic [31:0] a_mag, b_mag;
  logic [33:0] m_ext, d_ext, booth_add, shifted, rem_next;
  logic [66:0] booth_sum, booth_next;
  logic [4:0]  last_iter;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign a_mag     = data_operandA[31] ? -data_operandA : data_operandA;
  assign b_mag     = data_operandB[31] ? -data_operandB : data_operandB;
  assign m_ext     = {{2{mcand[31]}}, mcand};
  assign d_ext     = {2'b00, mcand};
  assign last_iter = (state == MULT) ? 5'd15 : 5'd31;

  assign busy           = (state == MULT) || (state == DIV);
  assign data_resultRDY = (state == DONE);

  // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    booth_add = '0;
    case (prod[2:0])
      3'b001, 3'b010: booth_add = m_ext;
      3'b011:         booth_add = m_ext << 1;
      3'b100:         booth_add = -(m_ext << 1);
      3'b101, 3'b110: booth_add = -m_ext;
      default:        booth_add = '0;
    endcase
    booth_sum  = {prod[66:33] + booth_add, prod[32:0]};
    booth_next = {{2{booth_sum[66]}}, booth_sum[66:2]};

    shifted  = {rem[32:0], quo[31]};
    rem_next = rem[33] ? shifted + d_ext : shifted - d_ext;
  end

  always_comb begin
    state_next = state;
    case (state)
      MULT, DIV: if (fin) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = state;
    endcase
    // A start pulse wins over everything, aborting any operation in flight.
    if (ctrl_MULT)     state_next = MULT;
    else if (ctrl_DIV) state_next = DIV;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      counter        <= '0;
      fin            <= 1'b0;
      mcand          <= '0;
      prod           <= '0;
      rem            <= '0;
      quo            <= '0;
      neg_q          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        counter <= '0;
        fin     <= 1'b0;
        if (ctrl_MULT) begin
          mcand <= data_operandA;
          prod  <= {34'd0, data_operandB, 1'b0};
        end else begin
          mcand    <= b_mag;
          rem      <= '0;
          quo      <= a_mag;
          neg_q    <= data_operandA[31] ^ data_operandB[31];
          div_zero <= (data_operandB == '0);
          div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end
      end else if (state == MULT || state == DIV) begin
        if (!fin) begin
          if (state == MULT) prod <= booth_next;
          else begin
            rem <= rem_next;
            quo <= {quo[30:0], ~rem_next[33]};
          end
          counter <= counter + 5'd1;
          if (counter == last_iter) fin <= 1'b1;
        end else if (state == MULT) begin
          data_result    <= prod[32:1];
          data_exception <= (prod[64:33] != {32{prod[32]}});
        end else begin
          if (rem[33]) rem <= rem + d_ext;
          data_result    <= div_zero ? '0 : (neg_q ? -quo : quo);
          data_exception <= div_zero | div_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases plus random operations
// compared against plain signed arithmetic.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  function automatic void mult_ref(input logic [31:0] a, b, output logic [31:0] res, output logic exc);
    longint p;
    int     lo;
    p   = longint'($signed(a)) * longint'($signed(b));
    lo  = int'(p[31:0]);
    res = p[31:0];
    exc = (p != longint'(lo));
  endfunction

  function automatic void div_ref(input logic [31:0] a, b, output logic [31:0] res, output logic exc);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      res = '0; exc = 1'b1;
    end else if (sa == int'(32'h8000_0000) && sb == -1) begin
      res = 32'h8000_0000; exc = 1'b1;
    end else begin
      res = sa / sb; exc = 1'b0;
    end
  endfunction

  // Presents a start pulse for exactly one edge; returns #1 after that edge with operands scrambled.
  task automatic start_op(input bit do_mult, input bit do_div, input logic [31:0] a, b);
    @(negedge clock);
    ctrl_MULT = do_mult;
    ctrl_DIV  = do_div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Counts edges after the start edge until RDY; bounded so a missing RDY still ends.
  task automatic wait_rdy(input string tag, input int lat);
    int seen;
    bit busy_dropped;
    seen = 0;
    busy_dropped = 1'b0;
    for (int i = 1; i <= lat + 8 && seen == 0; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen = i;
      else if (!busy) busy_dropped = 1'b1;
    end
    check({tag, " latency"}, seen, lat);
    check({tag, " busy during op"}, {31'd0, busy_dropped}, 32'd0);
  endtask

  task automatic run_op(input string tag, input bit do_mult, input bit do_div, input logic [31:0] a, b);
    logic [31:0] exp_res;
    logic        exp_exc;
    int          lat;
    if (do_mult) begin
      mult_ref(a, b, exp_res, exp_exc);
      lat = 17;
    end else begin
      div_ref(a, b, exp_res, exp_exc);
      lat = 33;
    end
    start_op(do_mult, do_div, a, b);
    wait_rdy(tag, lat);
    check({tag, " result"}, data_result, exp_res);
    check({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
    check({tag, " busy at rdy"}, {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
    check({tag, " rdy one cycle"}, {31'd0, data_resultRDY}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check({tag, " result hold"}, data_result, exp_res);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int rdy_seen;
    rdy_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_seen++;
    end
    check({tag, " no rdy"}, rdy_seen, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          op_mult;

    #1;
    check("reset result", data_result, 32'd0);
    check("reset exception", {31'd0, data_exception}, 32'd0);
    check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    run_op("mult 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    run_op("mult ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    run_op("mult min*1", 1'b1, 1'b0, 32'h8000_0000, 32'd1);
    run_op("mult min*min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    run_op("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("div 100/-10", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF6);
    run_op("div 5/7", 1'b0, 1'b1, 32'd5, 32'd7);
    run_op("div 123/0", 1'b0, 1'b1, 32'd123, 32'd0);
    run_op("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div min/min", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);

    // Both strobes together: multiply runs, divide never reports.
    run_op("both high", 1'b1, 1'b1, 32'd6, 32'd3);
    expect_quiet("both high", 40);

    // Restart a multiply with a divide on its 10th cycle.
    start_op(1'b1, 1'b0, 32'd6, 32'd3);
    expect_quiet("restart pre", 9);
    start_op(1'b0, 1'b1, 32'd6, 32'd3);
    wait_rdy("restart div", 33);
    check("restart result", data_result, 32'd2);
    check("restart exception", {31'd0, data_exception}, 32'd0);

    // Back-to-back: a start on the edge leaving DONE is accepted.
    start_op(1'b1, 1'b0, 32'd5, 32'd9);
    wait_rdy("b2b first", 17);
    check("b2b first result", data_result, 32'd45);
    start_op(1'b0, 1'b1, 32'd45, 32'hFFFF_FFFB);
    wait_rdy("b2b second", 33);
    check("b2b second result", data_result, 32'hFFFF_FFF7);

    for (int n = 0; n < 16; n++) begin
      op_mult = n[0];
      case (n % 4)
        0, 1:    begin ra = $urandom; rb = $urandom; end
        2:       begin ra = $urandom_range(0, 2000) - 1000; rb = $urandom_range(0, 60) - 30; end
        default: begin ra = $urandom; rb = $urandom_range(0, 400) - 200; end
      endcase
      run_op(op_mult ? "rand mult" : "rand div", op_mult, !op_mult, ra, rb);
    end

    // Asynchronous reset in the middle of a divide.
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (12) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("midreset result", data_result, 32'd0);
    check("midreset exception", {31'd0, data_exception}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    expect_quiet("after reset", 40);
    run_op("mult 2*3", 1'b1, 1'b0, 32'd2, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
